// File: rtl/limit_event_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : limit_event_pkg
//  Description : Shared constants for the limit/mode event recorder. These
//                are the counter mode encodings, the event type codes and the
//                bit positions of the event word. Building with TIMESTAMP_EN
//                defined widens each entry by an 8-bit timestamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package limit_event_pkg;

    // Counter mode encodings, common to this block and the counter
    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_UPDOWN = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    // Event type field values
    localparam logic EVT_LIMIT = 1'b1;
    localparam logic EVT_MODE  = 1'b0;

    // Event word layout
    localparam int OVF_BIT   = 7;
    localparam int MODE_MSB  = 6;
    localparam int MODE_LSB  = 5;
    localparam int TYPE_BIT  = 4;
    localparam int COUNT_MSB = 3;
    localparam int COUNT_LSB = 0;
    localparam int EVT_W     = 8;

`ifdef TIMESTAMP_EN
    // The timestamp sits above the event word
    localparam int TS_W    = 8;
    localparam int TS_LSB  = 8;
    localparam int ENTRY_W = EVT_W + TS_W;
`else
    localparam int ENTRY_W = EVT_W;
`endif

    // Assemble the 8-bit event word from its fields
    function automatic logic [EVT_W-1:0] pack_event(
        input logic       ovf_mark,
        input logic [1:0] mode,
        input logic       evt_type,
        input logic [3:0] count
    );
        return {ovf_mark, mode, evt_type, count};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_core.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_core
//  Description : Single-clock FIFO with a show-ahead read port. When the FIFO
//                is full, a push is accepted only if a pop happens in the same
//                cycle. A pop while empty is ignored. The read data reads as
//                zero while the FIFO is empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_core #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      fill
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign fill    = count;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage is written on accepted pushes only and is not reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; occupancy follows push/pop balance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/limit_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : limit_event_fifo
//  Description : Watches the counter's at_limit flag and mode select. Each
//                limit rising edge and each mode change is recorded as an
//                event word in a FIFO, which a consumer drains with
//                valid/ready. Events lost because the FIFO was full set a
//                sticky overflow flag, and the next stored entry is marked.
//                Define TIMESTAMP_EN to add an 8-bit cycle timestamp to each
//                entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module limit_event_fifo
    import limit_event_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         count_in,
    input  logic [1:0]         mode_in,
    input  logic               at_limit_in,
    input  logic               capture_en,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [AW:0]        fill,
    output logic               overflow
);

    logic               at_limit_q;
    logic [1:0]         mode_q;
    logic               pend_ovf;
    logic               limit_evt;
    logic               mode_evt;
    logic               any_evt;
    logic               pop;
    logic               full;
    logic               empty;
    logic               drop;
    logic [ENTRY_W-1:0] entry;

    // A limit event is a rising edge, so a flag held high is counted once
    assign limit_evt = at_limit_in & ~at_limit_q & capture_en;
    assign mode_evt  = (mode_in != mode_q) & capture_en;
    assign any_evt   = limit_evt | mode_evt;
    assign rd_valid  = ~empty;
    assign pop       = rd_valid & rd_ready;
    // A pop in the same cycle frees a slot, so only full-without-pop drops
    assign drop      = any_evt & full & ~pop;

`ifdef TIMESTAMP_EN
    logic [7:0] ts;

    // Free-running cycle counter, wraps from 255 to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    assign entry = {ts, pack_event(pend_ovf, mode_in,
                                   limit_evt ? EVT_LIMIT : EVT_MODE, count_in)};
`else
    // When both events occur together the entry is typed as a limit event;
    // the new mode still appears in the mode field
    assign entry = pack_event(pend_ovf, mode_in,
                              limit_evt ? EVT_LIMIT : EVT_MODE, count_in);
`endif

    // History tracks the inputs even while capture is disabled, so
    // re-enabling capture does not replay edges missed while it was off
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            at_limit_q <= 1'b0;
            mode_q     <= MODE_UP;
        end else begin
            at_limit_q <= at_limit_in;
            mode_q     <= mode_in;
        end
    end

    // A drop marks the next accepted push; overflow stays set until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_ovf <= 1'b0;
            overflow <= 1'b0;
        end else if (drop) begin
            pend_ovf <= 1'b1;
            overflow <= 1'b1;
        end else if (any_evt) begin
            pend_ovf <= 1'b0;
        end
    end

    sync_fifo_core #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (any_evt),
        .wr_data (entry),
        .pop     (rd_ready),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .fill    (fill)
    );

endmodule
`default_nettype wire

// File: tb/tb_limit_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_limit_event_fifo
//  Description : Self-checking bench for limit_event_fifo. A queue-based
//                reference model tracks the expected contents, and directed
//                steps plus a random phase are compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_limit_event_fifo;
    import limit_event_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic               clk;
    logic               rst_n;
    logic [3:0]         count_in;
    logic [1:0]         mode_in;
    logic               at_limit_in;
    logic               capture_en;
    logic               rd_ready;
    logic               rd_valid;
    logic [ENTRY_W-1:0] rd_data;
    logic [AW:0]        fill;
    logic               overflow;

    limit_event_fifo #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .count_in    (count_in),
        .mode_in     (mode_in),
        .at_limit_in (at_limit_in),
        .capture_en  (capture_en),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .fill        (fill),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference model state
    logic [ENTRY_W-1:0] q[$];
    logic               m_at;
    logic [1:0]         m_mode;
    logic               m_pend;
    logic               m_ovf;
    logic [7:0]         m_ts;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_at   = 1'b0;
        m_mode = 2'b00;
        m_pend = 1'b0;
        m_ovf  = 1'b0;
        m_ts   = 8'd0;
    endtask

    task automatic check_all();
        logic [ENTRY_W-1:0] head;
        head = (q.size() != 0) ? q[0] : '0;
        chk("rd_valid", 16'(rd_valid), 16'(q.size() != 0));
        chk("rd_data",  16'(rd_data),  16'(head));
        chk("fill",     16'(fill),     16'(q.size()));
        chk("overflow", 16'(overflow), 16'(m_ovf));
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge
    task automatic cyc(input logic [3:0] c, input logic [1:0] m, input logic l,
                       input logic e, input logic r);
        logic               lim;
        logic               mch;
        logic               was_full;
        logic               popped;
        logic [ENTRY_W-1:0] word;
        logic [ENTRY_W-1:0] tmp;
        count_in    = c;
        mode_in     = m;
        at_limit_in = l;
        capture_en  = e;
        rd_ready    = r;
        lim      = l && !m_at && e;
        mch      = e && (m != m_mode);
        was_full = (q.size() == DEPTH);
        popped   = r && (q.size() != 0);
`ifdef TIMESTAMP_EN
        word = {m_ts, m_pend, m, lim, c};
`else
        word = {m_pend, m, lim, c};
`endif
        if (popped) tmp = q.pop_front();
        if (lim || mch) begin
            if (!was_full || popped) begin
                q.push_back(word);
                m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
                m_ovf  = 1'b1;
            end
        end
        m_at   = l;
        m_mode = m;
        m_ts   = m_ts + 8'd1;
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst_n       = 1'b0;
        count_in    = 4'h0;
        mode_in     = 2'b00;
        at_limit_in = 1'b0;
        capture_en  = 1'b0;
        rd_ready    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Limit rise held for 5 cycles yields exactly one entry
        cyc(4'hF, MODE_UP, 1'b1, 1'b1, 1'b0);
        chk("limit_entry", 16'(rd_data[7:0]), 16'h001F);
        chk("limit_fill", 16'(fill), 16'd1);
        repeat (4) cyc(4'hF, MODE_UP, 1'b1, 1'b1, 1'b0);
        chk("limit_held_fill", 16'(fill), 16'd1);
        cyc(4'h0, MODE_UP, 1'b0, 1'b1, 1'b1);

        // Mode change, then mode change together with a limit rise
        cyc(4'h7, MODE_UPDOWN, 1'b0, 1'b1, 1'b0);
        chk("mode_entry", 16'(rd_data[7:0]), 16'h0047);
        cyc(4'h0, MODE_DOWN, 1'b1, 1'b1, 1'b1);
        chk("both_entry", 16'(rd_data[7:0]), 16'h0030);
        cyc(4'h0, MODE_DOWN, 1'b0, 1'b1, 1'b1);

        // Fill with eight mode events
        for (int i = 0; i < 8; i++)
            cyc(4'(i), (i % 2 == 0) ? MODE_UP : MODE_DOWN, 1'b0, 1'b1, 1'b0);
        chk("full_fill", 16'(fill), 16'd8);

        // Full with a simultaneous pop: push accepted, no overflow
        cyc(4'h5, MODE_UPDOWN, 1'b0, 1'b1, 1'b1);
        chk("full_pop_fill", 16'(fill), 16'd8);
        chk("full_pop_ovf", 16'(overflow), 16'd0);

        // Ten events while full and not draining
        for (int i = 0; i < 10; i++)
            cyc(4'(i), (i % 2 == 0) ? MODE_UP : MODE_HOLD, 1'b0, 1'b1, 1'b0);
        chk("ovf_set", 16'(overflow), 16'd1);

        // Drain one with capture off, then push a marked limit entry
        cyc(4'h0, MODE_UP, 1'b0, 1'b0, 1'b1);
        cyc(4'h3, MODE_UP, 1'b1, 1'b1, 1'b0);
        repeat (7) cyc(4'h0, MODE_UP, 1'b1, 1'b0, 1'b1);
        chk("ovf_mark_entry", 16'(rd_data[7:0]), 16'h0093);
        cyc(4'h0, MODE_UP, 1'b0, 1'b0, 1'b1);
        cyc(4'h4, MODE_UP, 1'b1, 1'b1, 1'b0);
        chk("after_mark_entry", 16'(rd_data[7:0]), 16'h0014);
        cyc(4'h0, MODE_UP, 1'b0, 1'b1, 1'b1);
        chk("drained_data", 16'(rd_data), 16'h0000);

        // Capture disabled while modes toggle: nothing stored
        for (int i = 0; i < 6; i++)
            cyc(4'(i), 2'(i), 1'(i % 2), 1'b0, 1'b0);
        chk("gated_fill", 16'(fill), 16'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cyc(4'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
                ($urandom_range(0, 7) != 0), ($urandom_range(0, 3) == 0));

        // Reset in the middle of a drain
        for (int i = 0; i < 5; i++)
            cyc(4'(i), (i % 2 == 0) ? MODE_HOLD : MODE_DOWN, 1'b0, 1'b1, 1'b0);
        cyc(4'h0, MODE_DOWN, 1'b0, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        mode_in     = MODE_UP;
        at_limit_in = 1'b0;
        capture_en  = 1'b0;

`ifdef TIMESTAMP_EN
        // The event pushed on the 21st edge after release carries ts=20
        repeat (20) cyc(4'h0, MODE_UP, 1'b0, 1'b0, 1'b0);
        cyc(4'h9, MODE_UP, 1'b1, 1'b1, 1'b0);
        chk("timestamp", 16'(rd_data[15:8]), 16'd20);
`endif

        // Non-zero mode after reset release produces a mode event
        cyc(4'h2, MODE_HOLD, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc(4'h0, MODE_HOLD, 1'b0, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
